// File: rtl/write_back_stage.sv
// ----------------------------------------------------------------------------
// write_back_stage
//
// Final pipeline stage between the memory stage and the 32-entry register
// file. Each cycle it captures one instruction, picks the result (ALU, load,
// link value or upper immediate), extends sub-word loads, and drives the
// register file write port from the held copy. It also bypasses the value
// being written this cycle onto the decode read ports, and counts retired
// instructions.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-low reset
//   Valid_i             memory stage presents an instruction
//   Flush_i             drop the incoming instruction, insert a bubble
//   Reg_Write_i         instruction writes a register
//   Write_Register_i    destination register
//   Mem_To_Reg_i        result select: 00 ALU, 01 load, 10 PC+4, 11 immediate
//   Load_Size_i         00 byte, 01 half, 10/11 word
//   Load_Unsigned_i     1 zero-extends, 0 sign-extends sub-word loads
//   ALU_Result_i        ALU result, bits [1:0] are the load byte offset
//   Mem_Data_i          raw aligned memory word
//   PC_Plus_4_i         link value
//   Imm_i               upper-immediate value
//   Read_Register_k_i   decode read addresses (k = 1, 2)
//   Read_Data_k_i       register file read data (k = 1, 2)
//   Reg_Write_o         register file write enable
//   Write_Register_o    register file write address
//   Write_Data_o        register file write data
//   Fwd_Data_k_o        read data with same-cycle write bypass (k = 1, 2)
//   Retired_Count_o     count of valid instructions leaving this stage
// ----------------------------------------------------------------------------
module write_back_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Valid_i,
    input  logic         Flush_i,
    input  logic         Reg_Write_i,
    input  logic [4:0]   Write_Register_i,
    input  logic [1:0]   Mem_To_Reg_i,
    input  logic [1:0]   Load_Size_i,
    input  logic         Load_Unsigned_i,
    input  logic [N-1:0] ALU_Result_i,
    input  logic [N-1:0] Mem_Data_i,
    input  logic [N-1:0] PC_Plus_4_i,
    input  logic [N-1:0] Imm_i,
    input  logic [4:0]   Read_Register_1_i,
    input  logic [4:0]   Read_Register_2_i,
    input  logic [N-1:0] Read_Data_1_i,
    input  logic [N-1:0] Read_Data_2_i,
    output logic         Reg_Write_o,
    output logic [4:0]   Write_Register_o,
    output logic [N-1:0] Write_Data_o,
    output logic [N-1:0] Fwd_Data_1_o,
    output logic [N-1:0] Fwd_Data_2_o,
    output logic [31:0]  Retired_Count_o
);

    // Pipeline register fields
    logic         r_wb_valid;
    logic         r_wb_regwrite;
    logic [4:0]   r_wb_rd;
    logic [N-1:0] r_wb_data;
    logic [31:0]  r_retired_count;

    logic [1:0]   w_off;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic [N-1:0] w_load_data;
    logic [N-1:0] w_result;
    logic         w_write_en;

    assign w_off = ALU_Result_i[1:0];

    // Load extraction: byte lanes follow the offset directly, halves only
    // look at off[1], and a word load ignores the offset entirely.
    always_comb begin
        w_byte      = '0;
        w_half      = '0;
        w_load_data = '0;
        case (w_off)
            2'd0:    w_byte = Mem_Data_i[7:0];
            2'd1:    w_byte = Mem_Data_i[15:8];
            2'd2:    w_byte = Mem_Data_i[23:16];
            default: w_byte = Mem_Data_i[31:24];
        endcase
        w_half = w_off[1] ? Mem_Data_i[31:16] : Mem_Data_i[15:0];
        case (Load_Size_i)
            2'b00: begin
                if (Load_Unsigned_i)
                    w_load_data = {{(N-8){1'b0}}, w_byte};
                else
                    w_load_data = {{(N-8){w_byte[7]}}, w_byte};
            end
            2'b01: begin
                if (Load_Unsigned_i)
                    w_load_data = {{(N-16){1'b0}}, w_half};
                else
                    w_load_data = {{(N-16){w_half[15]}}, w_half};
            end
            default: w_load_data = Mem_Data_i;
        endcase
    end

    // Result select
    always_comb begin
        w_result = '0;
        case (Mem_To_Reg_i)
            2'b00:   w_result = ALU_Result_i;
            2'b01:   w_result = w_load_data;
            2'b10:   w_result = PC_Plus_4_i;
            default: w_result = Imm_i;
        endcase
    end

    // R0 is physically writable in the register file, so the write enable
    // must be killed here for rd == 0.
    assign w_write_en = Reg_Write_i & (Write_Register_i != 5'd0);

    // Pipeline register: reset beats flush beats an invalid slot; any of
    // them captures a bubble so nothing stale can be written later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
        end else if (Flush_i || !Valid_i) begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
        end else begin
            r_wb_valid    <= 1'b1;
            r_wb_regwrite <= w_write_en;
            r_wb_rd       <= Write_Register_i;
            r_wb_data     <= w_result;
        end
    end

    // The held instruction retires at the edge that ends its write cycle,
    // whether or not it actually writes a register. Wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retired_count <= '0;
        end else if (r_wb_valid) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    assign Reg_Write_o      = r_wb_valid & r_wb_regwrite;
    assign Write_Register_o = r_wb_rd;
    assign Write_Data_o     = r_wb_data;
    assign Retired_Count_o  = r_retired_count;

    // Same-cycle bypass: the register file commits only at the next edge,
    // so decode must see the in-flight write value now.
    assign Fwd_Data_1_o = (Reg_Write_o && (Write_Register_o == Read_Register_1_i))
                          ? Write_Data_o : Read_Data_1_i;
    assign Fwd_Data_2_o = (Reg_Write_o && (Write_Register_o == Read_Register_2_i))
                          ? Write_Data_o : Read_Data_2_i;

endmodule

// File: tb/tb_write_back_stage.sv
// ----------------------------------------------------------------------------
// tb_write_back_stage
//
// Table-driven bench for write_back_stage: each vector drives one instruction
// plus read addresses and gives the hand-computed write port and bypass
// values expected in the following cycle. The retired count is tracked by a
// small reference model. Hand-written sequences cover reset, counter wrap and
// reset arriving while a write is held.
// ----------------------------------------------------------------------------
module tb_write_back_stage;

    localparam logic [31:0] MEM_WORD = 32'h80FF_7F01;
    localparam logic [31:0] PC4_VAL  = 32'h0040_0104;
    localparam logic [31:0] IMM_VAL  = 32'hABCD_E000;
    localparam logic [31:0] RD1_VAL  = 32'h1111_1111;
    localparam logic [31:0] RD2_VAL  = 32'h2222_2222;

    logic        clk = 1'b0;
    logic        reset;
    logic        Valid_i, Flush_i, Reg_Write_i, Load_Unsigned_i;
    logic [4:0]  Write_Register_i, Read_Register_1_i, Read_Register_2_i;
    logic [1:0]  Mem_To_Reg_i, Load_Size_i;
    logic [31:0] ALU_Result_i, Mem_Data_i, PC_Plus_4_i, Imm_i;
    logic [31:0] Read_Data_1_i, Read_Data_2_i;
    logic        Reg_Write_o;
    logic [4:0]  Write_Register_o;
    logic [31:0] Write_Data_o, Fwd_Data_1_o, Fwd_Data_2_o, Retired_Count_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    write_back_stage #(.N(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .Valid_i           (Valid_i),
        .Flush_i           (Flush_i),
        .Reg_Write_i       (Reg_Write_i),
        .Write_Register_i  (Write_Register_i),
        .Mem_To_Reg_i      (Mem_To_Reg_i),
        .Load_Size_i       (Load_Size_i),
        .Load_Unsigned_i   (Load_Unsigned_i),
        .ALU_Result_i      (ALU_Result_i),
        .Mem_Data_i        (Mem_Data_i),
        .PC_Plus_4_i       (PC_Plus_4_i),
        .Imm_i             (Imm_i),
        .Read_Register_1_i (Read_Register_1_i),
        .Read_Register_2_i (Read_Register_2_i),
        .Read_Data_1_i     (Read_Data_1_i),
        .Read_Data_2_i     (Read_Data_2_i),
        .Reg_Write_o       (Reg_Write_o),
        .Write_Register_o  (Write_Register_o),
        .Write_Data_o      (Write_Data_o),
        .Fwd_Data_1_o      (Fwd_Data_1_o),
        .Fwd_Data_2_o      (Fwd_Data_2_o),
        .Retired_Count_o   (Retired_Count_o)
    );

    typedef struct {
        logic        valid;
        logic        flush;
        logic        regWrite;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] alu;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic        expRegWrite;
        logic [4:0]  expRd;
        logic [31:0] expData;
        logic [31:0] expFwd1;
        logic [31:0] expFwd2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic f, logic rw, logic [4:0] rd,
                                logic [1:0] sel, logic [1:0] size, logic uns,
                                logic [31:0] alu, logic [4:0] rr1, logic [4:0] rr2,
                                logic eRw, logic [4:0] eRd, logic [31:0] eData,
                                logic [31:0] eF1, logic [31:0] eF2);
        vec_t t;
        t.valid = v;  t.flush = f;  t.regWrite = rw;  t.rd = rd;
        t.sel = sel;  t.size = size;  t.uns = uns;  t.alu = alu;
        t.rr1 = rr1;  t.rr2 = rr2;
        t.expRegWrite = eRw;  t.expRd = eRd;  t.expData = eData;
        t.expFwd1 = eF1;  t.expFwd2 = eF2;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one instruction (sampled at the next rising edge)
    task automatic applyStimulus(input vec_t t);
        Valid_i           = t.valid;
        Flush_i           = t.flush;
        Reg_Write_i       = t.regWrite;
        Write_Register_i  = t.rd;
        Mem_To_Reg_i      = t.sel;
        Load_Size_i       = t.size;
        Load_Unsigned_i   = t.uns;
        ALU_Result_i      = t.alu;
        Read_Register_1_i = t.rr1;
        Read_Register_2_i = t.rr2;
    endtask

    task automatic idleInputs();
        Valid_i = 1'b0;  Flush_i = 1'b0;  Reg_Write_i = 1'b0;
        Write_Register_i = 5'd0;  Mem_To_Reg_i = 2'b00;  Load_Size_i = 2'b10;
        Load_Unsigned_i = 1'b0;  ALU_Result_i = 32'h0;
        Read_Register_1_i = 5'd1;  Read_Register_2_i = 5'd2;
    endtask

    // Reference model of the retired counter
    logic        expHeld;
    logic [31:0] expCount;

    initial begin
        Mem_Data_i    = MEM_WORD;
        PC_Plus_4_i   = PC4_VAL;
        Imm_i         = IMM_VAL;
        Read_Data_1_i = RD1_VAL;
        Read_Data_2_i = RD2_VAL;
        idleInputs();

        //            v  f  rw rd     sel    size   uns alu            rr1    rr2    eRw eRd    eData           eF1            eF2
        vecs.push_back(mk(1, 0, 1, 5'd5,  2'b00, 2'b10, 0, 32'h1234_5678, 5'd5,  5'd31, 1, 5'd5,  32'h1234_5678, 32'h1234_5678, RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd6,  2'b01, 2'b00, 0, 32'h0000_0003, 5'd6,  5'd31, 1, 5'd6,  32'hFFFF_FF80, 32'hFFFF_FF80, RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd6,  2'b01, 2'b00, 1, 32'h0000_0001, 5'd6,  5'd31, 1, 5'd6,  32'h0000_007F, 32'h0000_007F, RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd6,  2'b01, 2'b01, 0, 32'h0000_0002, 5'd6,  5'd31, 1, 5'd6,  32'hFFFF_80FF, 32'hFFFF_80FF, RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd6,  2'b01, 2'b01, 1, 32'h0000_0001, 5'd6,  5'd31, 1, 5'd6,  32'h0000_7F01, 32'h0000_7F01, RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd10, 2'b01, 2'b10, 0, 32'h0000_0003, 5'd10, 5'd31, 1, 5'd10, MEM_WORD,      MEM_WORD,      RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd10, 2'b01, 2'b11, 1, 32'h0000_0002, 5'd10, 5'd31, 1, 5'd10, MEM_WORD,      MEM_WORD,      RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd11, 2'b01, 2'b00, 0, 32'h0000_0002, 5'd11, 5'd31, 1, 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd11, 2'b01, 2'b01, 1, 32'h0000_0003, 5'd11, 5'd31, 1, 5'd11, 32'h0000_80FF, 32'h0000_80FF, RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd11, 2'b01, 2'b00, 1, 32'h0000_0000, 5'd11, 5'd31, 1, 5'd11, 32'h0000_0001, 32'h0000_0001, RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd12, 2'b10, 2'b10, 0, 32'h0000_0000, 5'd12, 5'd31, 1, 5'd12, PC4_VAL,       PC4_VAL,       RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd13, 2'b11, 2'b10, 0, 32'h0000_0000, 5'd1,  5'd13, 1, 5'd13, IMM_VAL,       RD1_VAL,       IMM_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd0,  2'b00, 2'b10, 0, 32'hDEAD_BEEF, 5'd0,  5'd0,  0, 5'd0,  32'hDEAD_BEEF, RD1_VAL,       RD2_VAL));
        vecs.push_back(mk(1, 0, 0, 5'd9,  2'b00, 2'b10, 0, 32'h0000_0055, 5'd9,  5'd31, 0, 5'd9,  32'h0000_0055, RD1_VAL,       RD2_VAL));
        vecs.push_back(mk(0, 0, 1, 5'd4,  2'b00, 2'b10, 0, 32'h0000_0077, 5'd0,  5'd4,  0, 5'd0,  32'h0000_0000, RD1_VAL,       RD2_VAL));
        vecs.push_back(mk(1, 1, 1, 5'd4,  2'b00, 2'b10, 0, 32'h0000_0099, 5'd0,  5'd4,  0, 5'd0,  32'h0000_0000, RD1_VAL,       RD2_VAL));
        vecs.push_back(mk(1, 0, 1, 5'd7,  2'b00, 2'b10, 0, 32'hA5A5_A5A5, 5'd7,  5'd7,  1, 5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5));
        vecs.push_back(mk(1, 0, 1, 5'd7,  2'b00, 2'b10, 0, 32'hA5A5_A5A5, 5'd7,  5'd8,  1, 5'd7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, RD2_VAL));
        vecs.push_back(mk(1, 1, 1, 5'd3,  2'b00, 2'b10, 0, 32'h0000_0033, 5'd7,  5'd3,  0, 5'd0,  32'h0000_0000, RD1_VAL,       RD2_VAL));

        // Reset held low for two edges while a valid instruction is offered
        reset = 1'b0;
        applyStimulus(vecs[0]);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("reset Reg_Write_o", {31'd0, Reg_Write_o}, 32'd0);
            checkOutput("reset Write_Register_o", {27'd0, Write_Register_o}, 32'd0);
            checkOutput("reset Write_Data_o", Write_Data_o, 32'd0);
            checkOutput("reset Retired_Count_o", Retired_Count_o, 32'd0);
            checkOutput("reset Fwd_Data_1_o", Fwd_Data_1_o, RD1_VAL);
        end
        reset    = 1'b1;
        expHeld  = 1'b0;
        expCount = 32'd0;

        // Main table
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            if (expHeld) expCount = expCount + 32'd1;
            expHeld = vecs[i].valid & ~vecs[i].flush;
            @(negedge clk);
            checkOutput($sformatf("v%0d Reg_Write_o", i), {31'd0, Reg_Write_o}, {31'd0, vecs[i].expRegWrite});
            checkOutput($sformatf("v%0d Write_Register_o", i), {27'd0, Write_Register_o}, {27'd0, vecs[i].expRd});
            checkOutput($sformatf("v%0d Write_Data_o", i), Write_Data_o, vecs[i].expData);
            checkOutput($sformatf("v%0d Fwd_Data_1_o", i), Fwd_Data_1_o, vecs[i].expFwd1);
            checkOutput($sformatf("v%0d Fwd_Data_2_o", i), Fwd_Data_2_o, vecs[i].expFwd2);
            checkOutput($sformatf("v%0d Retired_Count_o", i), Retired_Count_o, expCount);
        end

        // Counter wrap: hold a valid instruction, preset the count to all ones
        applyStimulus(mk(1, 0, 1, 5'd3, 2'b00, 2'b10, 0, 32'h0000_0042, 5'd3, 5'd4,
                         1, 5'd3, 32'h42, 32'h42, RD2_VAL));
        @(posedge clk);
        @(negedge clk);
        checkOutput("wrap held Write_Data_o", Write_Data_o, 32'h0000_0042);
        force dut.r_retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired_count;
        idleInputs();
        @(posedge clk);
        @(negedge clk);
        checkOutput("wrap Retired_Count_o", Retired_Count_o, 32'd0);
        checkOutput("wrap bubble Reg_Write_o", {31'd0, Reg_Write_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("after bubble Retired_Count_o", Retired_Count_o, 32'd0);

        // Reset arriving while a write is held: the new input is dropped
        applyStimulus(mk(1, 0, 1, 5'd20, 2'b00, 2'b10, 0, 32'h0000_0001, 5'd20, 5'd2,
                         1, 5'd20, 32'h1, 32'h1, RD2_VAL));
        @(posedge clk);
        @(negedge clk);
        checkOutput("pre-reset Reg_Write_o", {31'd0, Reg_Write_o}, 32'd1);
        checkOutput("pre-reset Fwd_Data_1_o", Fwd_Data_1_o, 32'h0000_0001);
        reset = 1'b0;
        Write_Register_i = 5'd21;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid-reset Reg_Write_o", {31'd0, Reg_Write_o}, 32'd0);
        checkOutput("mid-reset Write_Data_o", Write_Data_o, 32'd0);
        checkOutput("mid-reset Retired_Count_o", Retired_Count_o, 32'd0);
        reset = 1'b1;
        idleInputs();
        @(posedge clk);
        @(negedge clk);
        checkOutput("post-reset Retired_Count_o", Retired_Count_o, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
